// File: rtl/nms_stream.sv
// Streaming 3x3 non-maximum suppression for the FAST9 pipeline.
// Two score line buffers plus a 3x3 window replace random-access score
// fetches. A pixel delay line keeps the centre pixel aligned with its window.
// After the last pixel of a frame the block injects IMG_W+1 zero-score
// pseudo-pixels so that the bottom rows are decided without waiting for the
// next frame.
module nms_stream #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int SCORE_W = 8,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 15
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic               mode,
  input  logic               inValid,
  output logic               inReady,
  input  logic [SCORE_W-1:0] inScore,
  input  logic [PIX_W-1:0]   inPixel,
  output logic               outValid,
  output logic               outCorner,
  output logic [PIX_W-1:0]   outPixel,
  output logic [ADDR_W-1:0]  outAddr
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int KW = $clog2(IMG_W * IMG_H + IMG_W + 1);

  localparam logic [KW-1:0] K_LAST_PIX  = KW'(IMG_W * IMG_H - 1);
  localparam logic [KW-1:0] K_FIRST_OUT = KW'(IMG_W + 1);
  localparam logic [KW-1:0] K_LAST      = KW'(IMG_W * IMG_H + IMG_W);
  localparam logic [CW-1:0] COL_MAX     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX     = RW'(IMG_H - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [KW-1:0]     k_q;
  logic [CW-1:0]     col_q;
  logic [CW-1:0]     cCol_q;
  logic [RW-1:0]     cRow_q;
  logic [ADDR_W-1:0] addr_q;

  logic               outValid_q;
  logic               outCorner_q;
  logic [PIX_W-1:0]   outPixel_q;
  logic [ADDR_W-1:0]  outAddr_q;

  logic [SCORE_W-1:0] lineA_q [IMG_W];
  logic [SCORE_W-1:0] lineB_q [IMG_W];
  logic [SCORE_W-1:0] win_q [3][2];
  logic [SCORE_W-1:0] nw [3][3];
  logic [PIX_W-1:0]   pd_q [IMG_W+1];

  logic               step;
  logic [SCORE_W-1:0] newScore;
  logic [PIX_W-1:0]   newPix;
  logic [SCORE_W-1:0] centre;
  logic               beatEarlier;
  logic               laterStrict;
  logic               laterTie;
  logic               border;
  logic               cornerD;

  assign outValid  = outValid_q;
  assign outCorner = outCorner_q;
  assign outPixel  = outPixel_q;
  assign outAddr   = outAddr_q;

  // Next-state logic: RUN takes input, FLUSH injects zero-score pixels every cycle.
  always_comb begin
    state_d  = state_q;
    inReady  = 1'b0;
    step     = 1'b0;
    newScore = '0;
    newPix   = '0;
    case (state_q)
      RUN: begin
        inReady  = 1'b1;
        step     = inValid;
        newScore = inScore;
        newPix   = inPixel;
        if (inValid && (k_q == K_LAST_PIX)) state_d = FLUSH;
      end
      FLUSH: begin
        step = 1'b1;
        if (k_q == K_LAST) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Window as it will look after this step: shift left, new column on the right.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nw[i][0] = win_q[i][0];
      nw[i][1] = win_q[i][1];
    end
    nw[0][2] = lineB_q[col_q];
    nw[1][2] = lineA_q[col_q];
    nw[2][2] = newScore;
  end

  // Suppression decision; in tie mode a plateau keeps only its earliest raster member.
  always_comb begin
    centre      = nw[1][1];
    beatEarlier = (centre > nw[0][0]) && (centre > nw[0][1]) &&
                  (centre > nw[0][2]) && (centre > nw[1][0]);
    laterStrict = (centre > nw[1][2]) && (centre > nw[2][0]) &&
                  (centre > nw[2][1]) && (centre > nw[2][2]);
    laterTie    = (centre >= nw[1][2]) && (centre >= nw[2][0]) &&
                  (centre >= nw[2][1]) && (centre >= nw[2][2]);
    border      = (cCol_q == '0) || (cCol_q == COL_MAX) ||
                  (cRow_q == '0) || (cRow_q == ROW_MAX);
    cornerD     = (centre != '0) && !border && beatEarlier &&
                  (mode ? laterTie : laterStrict);
  end

  // Control counters and registered outputs; border masking makes stale data harmless.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= RUN;
      k_q         <= '0;
      col_q       <= '0;
      cCol_q      <= '0;
      cRow_q      <= '0;
      addr_q      <= '0;
      outValid_q  <= 1'b0;
      outCorner_q <= 1'b0;
      outPixel_q  <= '0;
      outAddr_q   <= '0;
    end else begin
      state_q     <= state_d;
      outValid_q  <= 1'b0;
      outCorner_q <= 1'b0;
      outPixel_q  <= '0;
      if (step) begin
        if (k_q >= K_FIRST_OUT) begin
          outValid_q  <= 1'b1;
          outCorner_q <= cornerD;
          outPixel_q  <= cornerD ? pd_q[IMG_W] : '0;
          outAddr_q   <= addr_q;
          addr_q      <= addr_q + ADDR_W'(1);
          if (cCol_q == COL_MAX) begin
            cCol_q <= '0;
            cRow_q <= (cRow_q == ROW_MAX) ? '0 : cRow_q + RW'(1);
          end else begin
            cCol_q <= cCol_q + CW'(1);
          end
        end
        if ((state_q == FLUSH) && (k_q == K_LAST)) begin
          k_q    <= '0;
          col_q  <= '0;
          cCol_q <= '0;
          cRow_q <= '0;
          addr_q <= '0;
        end else begin
          k_q   <= k_q + KW'(1);
          col_q <= (col_q == COL_MAX) ? '0 : col_q + CW'(1);
        end
      end
    end
  end

  // Score line buffers, window and pixel delay line advance on every step.
  always_ff @(posedge clock) begin
    if (step) begin
      lineB_q[col_q] <= lineA_q[col_q];
      lineA_q[col_q] <= newScore;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= nw[i][1];
        win_q[i][1] <= nw[i][2];
      end
      pd_q[0] <= newPix;
      for (int i = 1; i <= IMG_W; i++) pd_q[i] <= pd_q[i-1];
    end
  end

endmodule
